// File: rtl/csr_out_queue.sv
// CSRW output stage: updates the three architectural output registers and
// queues every CSRW as a {port,data} record that drains over a val/rdy stream.
module csr_out_queue #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csrw_out0_en_W,
    input  logic             csrw_out1_en_W,
    input  logic             csrw_out2_en_W,
    input  logic [31:0]      csrw_data_W,
    output logic [31:0]      out0,
    output logic [31:0]      out1,
    output logic [31:0]      out2,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [33:0]      ostream_msg,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             overflow_clr
);

    // Stream handshake: a record transfers on any cycle where ostream_val and
    // ostream_rdy are both high; msg is held stable while val is high and rdy low.

    logic [33:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [31:0]      out0_q, out0_d;
    logic [31:0]      out1_q, out1_d;
    logic [31:0]      out2_q, out2_d;

    logic       wr_req;
    logic       deq;
    logic       enq;
    logic       drop;
    logic [1:0] port_code;

    assign wr_req = csrw_out0_en_W | csrw_out1_en_W | csrw_out2_en_W;
    assign deq    = (count_q != '0) & ostream_rdy;
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq    = wr_req & ((count_q != CNT_W'(DEPTH)) | deq);
    assign drop   = wr_req & ~enq;

    always_comb begin
        port_code = 2'd2;
        if (csrw_out0_en_W) begin
            port_code = 2'd0;
        end else if (csrw_out1_en_W) begin
            port_code = 2'd1;
        end
    end

    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        out2_d = out2_q;
        if (csrw_out0_en_W) begin
            out0_d = csrw_data_W;
        end else if (csrw_out1_en_W) begin
            out1_d = csrw_data_W;
        end else if (csrw_out2_en_W) begin
            out2_d = csrw_data_W;
        end
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out0_q     <= '0;
            out1_q     <= '0;
            out2_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            out2_q     <= out2_d;
            if (enq) begin
                mem_q[wr_ptr_q] <= {port_code, csrw_data_W};
            end
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign ostream_val = (count_q != '0);
    assign ostream_msg = mem_q[rd_ptr_q];

endmodule
